// File: rtl/gdsp_pkg.sv
// Shared DSP datapath constants for the modem front end.
package gdsp_pkg;
  localparam int unsigned BITS_PER_SYM = 4;
endpackage

// File: rtl/qam16_symbol_packer.sv
// Byte-to-nibble packer feeding the 16-QAM mapper at a fixed symbol rate.
// Bytes are buffered in a small FIFO and released high nibble first, one symbol per SPS clocks.
module qam16_symbol_packer
  import gdsp_pkg::*;
#(
  parameter int unsigned SPS   = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  output logic                          byte_ready,
  input  logic                          enable,
  input  logic                          flush,
  output logic [BITS_PER_SYM-1:0]       sym_out,
  output logic                          sym_valid,
  output logic                          underrun,
  output logic [$clog2(DEPTH):0]        fifo_level
);

  localparam int unsigned CNT_W = $clog2(SPS);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  phase_t                  phase_q, phase_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]        level_q;
  logic [7:0]              mem [DEPTH];
  logic [7:0]              head;
  logic [BITS_PER_SYM-1:0] nibble_c;
  logic [BITS_PER_SYM-1:0] sym_out_q;
  logic                    sym_valid_q;
  logic                    underrun_q;
  logic                    full, empty, tick, emit, push, pop, starve;

  assign full   = (level_q == LVL_W'(DEPTH));
  assign empty  = (level_q == '0);
  assign tick   = enable && (cnt_q == '0);
  assign head   = mem[rd_ptr_q];

  // Flush dominates every other action in its cycle.
  assign emit   = tick && !empty && !flush;
  assign starve = tick && empty && !flush;
  assign push   = byte_valid && !full && !flush;
  assign pop    = emit && (phase_q == PH_LO);

  assign byte_ready = !full;
  assign sym_out    = sym_out_q;
  assign sym_valid  = sym_valid_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;

  // Symbol-rate timer, parked at zero while disabled so the first enabled cycle ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (flush || !enable) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(SPS - 1)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Nibble phase register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PH_HI;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Phase next-state and nibble select.
  always_comb begin
    phase_d  = phase_q;
    nibble_c = head[7:4];
    if (phase_q == PH_LO) begin
      nibble_c = head[3:0];
    end
    if (flush) begin
      phase_d = PH_HI;
    end else if (emit) begin
      phase_d = (phase_q == PH_HI) ? PH_LO : PH_HI;
    end
  end

  // FIFO storage; contents are only meaningful below fifo_level, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= byte_in;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  // Registered symbol strobe and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sym_valid_q <= emit;
      if (emit) begin
        sym_out_q <= nibble_c;
      end
      if (flush) begin
        underrun_q <= 1'b0;
      end else if (starve) begin
        underrun_q <= 1'b1;
      end
    end
  end

endmodule
